// File: rtl/cpp_internal_double_pkg.sv
// Shared IEEE-754 double constants and field layout
// for the integer/bool to double conversion stages.
package cpp_internal_double_pkg;

  localparam int DBL_EXP_BIAS = 1023;
  localparam int DBL_EXP_W    = 11;
  localparam int DBL_MANT_W   = 52;

  typedef struct packed {
    logic                  sign;
    logic [DBL_EXP_W-1:0]  exp;
    logic [DBL_MANT_W-1:0] mant;
  } dbl_t;

endpackage

// File: rtl/cpp_internal_bool_period_to_double_if.sv
// Bool stream in, double-coded period out, each
// qualified by a toggle-coded update strobe.
interface cpp_internal_bool_period_to_double_if;

  logic        in;
  logic        update_in;
  logic [63:0] out;
  logic        update_out;
  logic        valid;
  logic        overflow;

  modport master (
    output in,
    output update_in,
    input  out,
    input  update_out,
    input  valid,
    input  overflow
  );

  modport slave (
    input  in,
    input  update_in,
    output out,
    output update_out,
    output valid,
    output overflow
  );

endinterface

// File: rtl/cpp_internal_uint_to_double.sv
// Two-register unsigned integer to double pipeline:
// input capture, then LZC/normalise; pack is combinational.
module cpp_internal_uint_to_double
  import cpp_internal_double_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output dbl_t         out_dbl
);

  logic         v1_q;
  logic [W-1:0] d1_q;
  logic         v2_q;
  logic         z2_q;
  logic [5:0]   m2_q;
  logic [W-2:0] n2_q;

  logic [5:0]   msb;
  logic [W-1:0] norm;
  logic [DBL_MANT_W-1:0] mant;

  always_comb begin
    msb = '0;
    for (int i = 0; i < W; i++) begin
      if (d1_q[i]) msb = 6'(i);
    end
    norm = d1_q << (6'(W - 1) - msb);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      d1_q <= '0;
      v2_q <= 1'b0;
      z2_q <= 1'b1;
      m2_q <= '0;
      n2_q <= '0;
    end else begin
      v1_q <= in_valid;
      if (in_valid) d1_q <= in_data;
      v2_q <= v1_q;
      if (v1_q) begin
        m2_q <= msb;
        n2_q <= norm[W-2:0];
        z2_q <= ~norm[W-1];
      end
    end
  end

  // Leading one is implicit; remaining bits go left-aligned
  always_comb begin
    mant = '0;
    mant[DBL_MANT_W-1 -: W-1] = n2_q;
    out_dbl.sign = 1'b0;
    out_dbl.exp  = z2_q ? '0 :
      DBL_EXP_W'(DBL_EXP_BIAS + int'(m2_q));
    out_dbl.mant = z2_q ? '0 : mant;
  end

  assign out_valid = v2_q;

endmodule

// File: rtl/cpp_internal_bool_period_to_double.sv
// Measures update-event count between rising edges of a
// bool stream and emits each period as a double.
module cpp_internal_bool_period_to_double
  import cpp_internal_double_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst_n,
  cpp_internal_bool_period_to_double_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             upd_q;
  logic             prev_q;
  logic             armed_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             tog_q;
  logic             vld_q;
  dbl_t             out_q;

  logic             ev;
  logic             rise;
  logic             sat;
  logic             cap;
  logic [CNT_W-1:0] period;
  logic             dv;
  dbl_t             dbl;

  assign ev     = bus.update_in ^ upd_q;
  assign rise   = bus.in & ~prev_q;
  assign sat    = cnt_q >= CNT_MAX - 1'b1;
  assign cap    = ev & rise & armed_q;
  assign period = sat ? CNT_MAX : cnt_q + 1'b1;

  cpp_internal_uint_to_double #(
    .W (CNT_W)
  ) u_conv (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (cap),
    .in_data   (period),
    .out_valid (dv),
    .out_dbl   (dbl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_q   <= 1'b0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      upd_q <= bus.update_in;
      if (ev) begin
        prev_q <= bus.in;
        if (rise) begin
          armed_q <= 1'b1;
          cnt_q   <= '0;
          if (cap && sat) ovf_q <= 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      tog_q <= 1'b0;
      vld_q <= 1'b0;
    end else if (dv) begin
      out_q <= dbl;
      tog_q <= ~tog_q;
      vld_q <= 1'b1;
    end
  end

  assign bus.out        = out_q;
  assign bus.update_out = tog_q;
  assign bus.valid      = vld_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_cpp_internal_bool_period_to_double.sv
// Directed bench: period capture, max rate, saturation
// and reset behaviour for the bool-period-to-double stage.
module tb_cpp_internal_bool_period_to_double;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   tg32 = 0;
  int   tg4 = 0;
  logic p32 = 1'b0;
  logic p4 = 1'b0;
  int   t0;

  always #5 clk = ~clk;

  cpp_internal_bool_period_to_double_if b32 ();
  cpp_internal_bool_period_to_double_if b4 ();

  cpp_internal_bool_period_to_double #(
    .CNT_W (32)
  ) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b32)
  );

  cpp_internal_bool_period_to_double #(
    .CNT_W (4)
  ) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4)
  );

  always @(negedge clk) begin
    if (b32.update_out !== p32) tg32++;
    if (b4.update_out !== p4) tg4++;
    p32 = b32.update_out;
    p4  = b4.update_out;
  end

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ev32(input logic b);
    b32.in = b;
    b32.update_in = ~b32.update_in;
    tick(1);
  endtask

  task automatic ev4(input logic b);
    b4.in = b;
    b4.update_in = ~b4.update_in;
    tick(1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out"}, b32.out, 64'h0);
    check({tag, "_uo"}, 64'(b32.update_out), 64'h0);
    check({tag, "_vld"}, 64'(b32.valid), 64'h0);
    check({tag, "_ovf"}, 64'(b32.overflow), 64'h0);
  endtask

  initial begin
    b32.in = 1'b1;
    b32.update_in = 1'b1;
    b4.in = 1'b1;
    b4.update_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b32.in = 1'($urandom);
      b32.update_in = 1'($urandom);
      b4.in = 1'($urandom);
      b4.update_in = 1'($urandom);
      tick(1);
    end
    check_idle("rst");
    check("rst_out4", b4.out, 64'h0);
    b32.in = 1'b0;
    b32.update_in = 1'b0;
    b4.in = 1'b0;
    b4.update_in = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(4);
    check_idle("hold");

    // Period 3: first rising edge only arms
    t0 = tg32;
    ev32(1'b1);
    ev32(1'b0);
    ev32(1'b0);
    tick(3);
    check("arm_vld", 64'(b32.valid), 64'h0);
    ev32(1'b1);
    tick(1);
    check("p3_early", b32.out, 64'h0);
    tick(1);
    check("p3_out", b32.out, 64'h4008000000000000);
    check("p3_vld", 64'(b32.valid), 64'h1);
    tick(1);
    check("p3_tgl", 64'(tg32 - t0), 64'd1);

    t0 = tg32;
    for (int i = 0; i < 9; i++) ev32(1'b0);
    ev32(1'b1);
    tick(3);
    check("p10_out", b32.out, 64'h4024000000000000);
    ev32(1'b0);
    ev32(1'b1);
    tick(3);
    check("p2_out", b32.out, 64'h4000000000000000);
    check("p10p2_tgl", 64'(tg32 - t0), 64'd2);
    check("p2_ovf", 64'(b32.overflow), 64'h0);

    // One event per clock, alternating level
    t0 = tg32;
    for (int i = 0; i < 200; i++) ev32(1'(i % 2));
    tick(4);
    check("max_tgl", 64'(tg32 - t0), 64'd100);
    check("max_out", b32.out, 64'h4000000000000000);

    t0 = tg32;
    for (int i = 0; i < 6; i++) begin
      b32.in = ~b32.in;
      tick(1);
    end
    tick(3);
    check("noev_tgl", 64'(tg32 - t0), 64'd0);
    check("noev_out", b32.out, 64'h4000000000000000);

    // Saturation on the narrow counter
    t0 = tg4;
    ev4(1'b1);
    for (int i = 0; i < 20; i++) ev4(1'b0);
    tick(2);
    check("sat_pre_ovf", 64'(b4.overflow), 64'h0);
    ev4(1'b1);
    tick(3);
    check("sat_out", b4.out, 64'h402E000000000000);
    check("sat_ovf", 64'(b4.overflow), 64'h1);
    check("sat_tgl", 64'(tg4 - t0), 64'd1);
    ev4(1'b0);
    ev4(1'b0);
    ev4(1'b1);
    tick(3);
    check("sat_p3_out", b4.out, 64'h4008000000000000);
    check("sat_p3_ovf", 64'(b4.overflow), 64'h1);
    check("sat_p3_tgl", 64'(tg4 - t0), 64'd2);

    // Reset while a captured period is in flight
    ev32(1'b0);
    ev32(1'b1);
    tick(1);
    rst_n = 1'b0;
    #1;
    check_idle("mid");
    tick(2);
    b32.update_in = 1'b0;
    b4.update_in = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(5);
    check_idle("post");
    check("post_ovf4", 64'(b4.overflow), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpp_internal_bool_period_to_double.md
# cpp_internal_bool_period_to_double

Clocked measurement stage that sits directly downstream of the double-to-bool converter. It consumes that converter's `out`/`update_out` pair as a bool stream with a toggle-coded update strobe. It counts update events between successive rising edges of the bool, then emits each measured period as an IEEE-754 double with its own toggle strobe. The output feeds the double-domain modules, closing the bool→double loop for frequency and period monitors.

## Interface
Parameters:
- `CNT_W`, default 32: period counter width. Legal range is 2..52, which guarantees exact conversion.

Ports:
- `clk`  in  1  system clock; all inputs are synchronous to it.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in`  in  1  bool stream, from the upstream converter's `out`.
- `update_in`  in  1  toggle strobe; every level change is one update event.
- `out`  out  64  measured period as IEEE-754 double bits.
- `update_out`  out  1  toggles once per new `out` value.
- `valid`  out  1  goes high with the first emitted period and stays high.
- `overflow`  out  1  sticky; set when any period saturates.

## Operation
- Event detect: `upd_q` registers `update_in`. An event occurs on any edge where `update_in != upd_q`. Non-event edges change no state except pipeline advance.
- On each event, sample `in`:
  - Rising event (`in`=1, `prev_in`=0):
    - If `armed`=0, set `armed`=1 and emit nothing.
    - Otherwise capture P = min(`cnt`+1, 2^CNT_W−1) into the pipeline.
    - In both cases clear `cnt` to 0.
  - Any other event: `cnt` increments, saturating at 2^CNT_W−1.
  - `prev_in` is updated with the sampled `in`.
- Saturation:
  - If the captured P equals 2^CNT_W−1 and `cnt`+1 ≥ 2^CNT_W−1, set `overflow` (sticky until reset).
  - Saturation and a rising edge on the same event emit the saturated value.
- Minimum period is 2, because a rising edge requires a prior low sample. P=0 and P=1 never occur.
- Conversion (exact):
  - m = index of P's MSB.
  - sign = 0; exponent = 1023+m.
  - mantissa = (P << (52−m))[51:0].
- Events are ignored for measurement before the first rising edge.

## Timing
- Reset values:
  - Outputs: `out`=64'h0 (0.0), `update_out`=0, `valid`=0, `overflow`=0.
  - Internal: `upd_q`=0, `prev_in`=0, `armed`=0, `cnt`=0, pipeline valids=0.
  - A high `update_in` at reset release therefore counts as an event on the first edge.
- Pipeline, fully pipelined with throughput one period per clock and no stalls or drops:
  - Edge E0: event sampled and P captured into stage 1.
  - Edge E0+1: leading-zero count and normalising shift.
  - Edge E0+2: exponent/mantissa packed into `out`; `update_out` toggles; `valid` set.
- `out` is held stable between toggles.
- Back-to-back events every clock are legal. Alternating `in` then yields a new `out` every 2 clocks.
- Reset asserted mid-operation clears all stages immediately. No `update_out` toggle is produced for in-flight periods.

## Structure
- Package `cpp_internal_double_pkg` holds:
  - Constants: `DBL_EXP_BIAS`=1023, `DBL_EXP_W`=11, `DBL_MANT_W`=52.
  - Packed struct typedef `dbl_t` {sign, exp[10:0], mant[51:0]}.
- Sub-module `cpp_internal_uint_to_double`:
  - Parameterised by width.
  - Implements the two-stage LZC/shift/pack pipeline with input valid and output valid.
  - Reusable by other integer→double stages.
- The top level holds event detect, edge/arm logic, the counter and `update_out` toggling.

## Test plan
- **Reset**: assert `rst_n`=0 with random inputs → `out`=64'h0, `update_out`=0, `valid`=0, `overflow`=0. Hold those values through release with no events.
- **Period 3**:
  - Stimulus: events with `in` = 1,0,0,1.
  - First rising edge only arms.
  - Second rising edge, 2 clocks after its event → `out`=64'h4008000000000000, one `update_out` toggle, `valid`=1.
- **Period 10 then period 2**:
  - Expect `out`=64'h4024000000000000, then `out`=64'h4000000000000000.
  - Exactly two toggles.
- **Max rate**:
  - Stimulus: one event every clock, `in` alternating.
  - `out`=64'h4000000000000000 with a toggle every 2 clocks; no missed periods over 100 periods.
- **Saturation (CNT_W=4)**:
  - Stimulus: 20 events between rising edges.
  - Expect `out`=64'h402E000000000000 (15.0) and `overflow`=1.
  - `overflow` stays 1 after a subsequent normal period of 3.
- **No events / reset mid-flight**:
  - Toggle `in` with `update_in` static → no output change.
  - Assert reset one clock after a capturing event → no toggle, outputs return to reset values.
